alu_system_sequencer: RTL and testbench

//  Fetch/execute controller for ALUSystem. Drives every ALUSystem control input.
//  Per instruction: fetches a 16-bit instruction from memory at PC, low byte then high byte, into IR, then executes it in one cycle.

---
 rtl/alu_system_sequencer_if.sv | 55 +++++
 rtl/alu_system_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alu_system_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_system_sequencer_if.sv
// Control/status bundle between alu_system_sequencer and the ALUSystem datapath.
// The step input exists only when SEQ_SINGLE_STEP_EN is defined.
interface alu_system_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
`ifdef SEQ_SINGLE_STEP_EN
  logic             step;
`endif
  logic [15:0]      ir_out;
  logic [3:0]       alu_flag_out;
  logic [2:0]       rf_o1sel;
  logic [2:0]       rf_o2sel;
  logic [1:0]       rf_funsel;
  logic [3:0]       rf_rsel;
  logic [3:0]       rf_tsel;
  logic [3:0]       alu_funsel;
  logic [1:0]       arf_outasel;
  logic [1:0]       arf_outbsel;
  logic [1:0]       arf_funsel;
  logic [3:0]       arf_rsel;
  logic             ir_lh;
  logic             ir_enable;
  logic [1:0]       ir_funsel;
  logic             mem_wr;
  logic             mem_cs;
  logic [1:0]       muxasel;
  logic [1:0]       muxbsel;
  logic             muxcsel;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, ir_out, alu_flag_out,
`ifdef SEQ_SINGLE_STEP_EN
    input  step,
`endif
    output rf_o1sel, rf_o2sel, rf_funsel, rf_rsel, rf_tsel, alu_funsel,
           arf_outasel, arf_outbsel, arf_funsel, arf_rsel,
           ir_lh, ir_enable, ir_funsel, mem_wr, mem_cs,
           muxasel, muxbsel, muxcsel, busy, halted, instr_count
  );

  modport slave (
    output start, ir_out, alu_flag_out,
`ifdef SEQ_SINGLE_STEP_EN
    output step,
`endif
    input  rf_o1sel, rf_o2sel, rf_funsel, rf_rsel, rf_tsel, alu_funsel,
           arf_outasel, arf_outbsel, arf_funsel, arf_rsel,
           ir_lh, ir_enable, ir_funsel, mem_wr, mem_cs,
           muxasel, muxbsel, muxcsel, busy, halted, instr_count
  );
endinterface

// File: rtl/alu_system_sequencer.sv
// Fetch/execute controller for ALUSystem: two-byte fetch into IR, then one execute cycle.
// Define SEQ_SINGLE_STEP_EN to add the step input and a PAUSE state after every execute.
module alu_system_sequencer #(
  parameter int         CNT_W   = 16,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input logic                    clk_i,
  input logic                    rst_i,
  alu_system_sequencer_if.master bus_io
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE = 3'd5
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       op_s;
  logic [1:0]       rd_s;
  logic [1:0]       rs_s;
  logic [3:0]       rd_onehot_s;

  assign op_s        = bus_io.ir_out[15:12];
  assign rd_s        = bus_io.ir_out[11:10];
  assign rs_s        = bus_io.ir_out[9:8];
  assign rd_onehot_s = 4'b1000 >> rd_s;
  assign bus_io.instr_count = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Reset is folded in so the idle vector appears the instant rst_i rises.
  always_comb begin
    state_d            = state_q;
    count_d            = count_q;
    bus_io.rf_o1sel    = 3'b000;
    bus_io.rf_o2sel    = 3'b000;
    bus_io.rf_funsel   = 2'b00;
    bus_io.rf_rsel     = 4'b0000;
    bus_io.rf_tsel     = 4'b0000;
    bus_io.alu_funsel  = 4'b0000;
    bus_io.arf_outasel = 2'b00;
    bus_io.arf_outbsel = 2'b00;
    bus_io.arf_funsel  = 2'b00;
    bus_io.arf_rsel    = 4'b0000;
    bus_io.ir_lh       = 1'b0;
    bus_io.ir_enable   = 1'b0;
    bus_io.ir_funsel   = 2'b00;
    bus_io.mem_wr      = 1'b0;
    bus_io.mem_cs      = 1'b1;
    bus_io.muxasel     = 2'b00;
    bus_io.muxbsel     = 2'b00;
    bus_io.muxcsel     = 1'b0;
    bus_io.busy        = 1'b0;
    bus_io.halted      = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_IDLE, S_HALT: begin
          bus_io.halted = (state_q == S_HALT);
          if (bus_io.start) begin
            bus_io.arf_rsel   = 4'b0001;
            bus_io.arf_funsel = 2'b11;
            state_d           = S_FETCH_L;
          end else begin
            state_d = state_q;
          end
        end
        S_FETCH_L, S_FETCH_H: begin
          bus_io.busy        = 1'b1;
          bus_io.arf_outbsel = 2'b11;
          bus_io.mem_cs      = 1'b0;
          bus_io.ir_enable   = 1'b1;
          bus_io.ir_funsel   = 2'b10;
          bus_io.ir_lh       = (state_q == S_FETCH_H);
          bus_io.arf_rsel    = 4'b0001;
          bus_io.arf_funsel  = 2'b01;
          state_d            = (state_q == S_FETCH_L) ? S_FETCH_H : S_EXEC;
        end
        S_EXEC: begin
          bus_io.busy = 1'b1;
          count_d     = count_q + CNT_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
          state_d     = S_PAUSE;
`else
          state_d     = S_FETCH_L;
`endif
          if (op_s == HALT_OP) begin
            state_d = S_HALT;
          end else begin
            if (op_s <= 4'hD) begin
              bus_io.rf_o1sel = {1'b1, rd_s};
              bus_io.rf_o2sel = {1'b1, rs_s};
            end else begin
              bus_io.rf_o1sel = 3'b000;
            end
            case (op_s)
              4'h0: begin
                bus_io.muxasel   = 2'b10;
                bus_io.rf_funsel = 2'b10;
                bus_io.rf_rsel   = rd_onehot_s;
              end
              4'h1: begin
                bus_io.muxbsel    = 2'b10;
                bus_io.arf_funsel = 2'b10;
                bus_io.arf_rsel   = 4'b1000;
              end
              4'h2: begin
                bus_io.arf_outbsel = 2'b00;
                bus_io.mem_cs      = 1'b0;
                bus_io.muxasel     = 2'b01;
                bus_io.rf_funsel   = 2'b10;
                bus_io.rf_rsel     = rd_onehot_s;
              end
              4'h3: begin
                bus_io.alu_funsel  = 4'b0000;
                bus_io.muxcsel     = 1'b1;
                bus_io.arf_outbsel = 2'b00;
                bus_io.mem_cs      = 1'b0;
                bus_io.mem_wr      = 1'b1;
              end
              4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
                bus_io.alu_funsel = op_s;
                bus_io.muxcsel    = 1'b1;
                bus_io.muxasel    = 2'b00;
                bus_io.rf_funsel  = 2'b10;
                bus_io.rf_rsel    = rd_onehot_s;
              end
              4'hC: begin
                bus_io.rf_funsel = 2'b01;
                bus_io.rf_rsel   = rd_onehot_s;
              end
              4'hD: begin
                bus_io.rf_funsel = 2'b00;
                bus_io.rf_rsel   = rd_onehot_s;
              end
              4'hE: begin
                if (bus_io.alu_flag_out[3]) begin
                  bus_io.muxbsel    = 2'b10;
                  bus_io.arf_funsel = 2'b10;
                  bus_io.arf_rsel   = 4'b0001;
                end else begin
                  bus_io.arf_rsel = 4'b0000;
                end
              end
              default: bus_io.mem_cs = 1'b1;
            endcase
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          state_d = bus_io.step ? S_FETCH_L : S_PAUSE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_system_sequencer.sv
// Bench for alu_system_sequencer: behavioural ALUSystem datapath driven by the DUT, an
// instruction-level reference model feeding a scoreboard, and a retirement monitor.
module tb_alu_system_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_system_sequencer_if #(.CNT_W(16)) bus ();
  alu_system_sequencer #(.CNT_W(16), .HALT_OP(4'hF)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_SINGLE_STEP_EN
  assign bus.step = 1'b1;
`endif

  // ---------------- datapath environment ----------------
  logic [7:0]  mem [256];
  logic [7:0]  rf  [4];
  logic [7:0]  ar, sp, pc;
  logic [15:0] ir;
  logic        zf;
  logic        ld_en, env_clr;
  logic [7:0]  ld_addr, ld_data;
  logic [7:0]  outa_s, outb_s, mem_out_s, alu_a_s, alu_b_s, alu_out_s, muxa_s, muxb_s;

  function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'h4:    return a + b;
      4'h5:    return a - b;
      4'h6:    return a & b;
      4'h7:    return a | b;
      4'h8:    return a ^ b;
      4'h9:    return ~a;
      4'hA:    return a << 1;
      4'hB:    return a >> 1;
      default: return a;
    endcase
  endfunction

  function automatic logic [7:0] reg_f(input logic [1:0] f, input logic [7:0] cur, input logic [7:0] d);
    case (f)
      2'b00:   return cur - 8'd1;
      2'b01:   return cur + 8'd1;
      2'b10:   return d;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    case (bus.arf_outasel)
      2'd0: outa_s = ar;
      2'd1: outa_s = sp;
      2'd2: outa_s = 8'h00;
      default: outa_s = pc;
    endcase
    case (bus.arf_outbsel)
      2'd0: outb_s = ar;
      2'd1: outb_s = sp;
      2'd2: outb_s = 8'h00;
      default: outb_s = pc;
    endcase
    mem_out_s = mem[outb_s];
    alu_a_s   = bus.muxcsel ? rf[bus.rf_o1sel[1:0]] : outa_s;
    alu_b_s   = rf[bus.rf_o2sel[1:0]];
    alu_out_s = alu_f(bus.alu_funsel, alu_a_s, alu_b_s);
    case (bus.muxasel)
      2'd0: muxa_s = alu_out_s;
      2'd1: muxa_s = mem_out_s;
      2'd2: muxa_s = ir[7:0];
      default: muxa_s = outa_s;
    endcase
    case (bus.muxbsel)
      2'd0: muxb_s = alu_out_s;
      2'd1: muxb_s = mem_out_s;
      2'd2: muxb_s = ir[7:0];
      default: muxb_s = outa_s;
    endcase
  end

  assign bus.ir_out       = ir;
  assign bus.alu_flag_out = {zf, 3'b000};

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      ar <= 8'h00; sp <= 8'h00; pc <= 8'h00; ir <= 16'h0000; zf <= 1'b0;
    end else begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (!bus.mem_cs && bus.mem_wr) mem[outb_s] <= alu_out_s;
      for (int i = 0; i < 4; i++) begin
        if (bus.rf_rsel[3-i]) begin
          rf[i] <= reg_f(bus.rf_funsel, rf[i], muxa_s);
          zf    <= (reg_f(bus.rf_funsel, rf[i], muxa_s) == 8'h00);
        end
      end
      if (bus.arf_rsel[3]) ar <= reg_f(bus.arf_funsel, ar, muxb_s);
      if (bus.arf_rsel[2]) sp <= reg_f(bus.arf_funsel, sp, muxb_s);
      if (bus.arf_rsel[0]) pc <= reg_f(bus.arf_funsel, pc, muxb_s);
      if (bus.ir_enable && bus.ir_funsel == 2'b10) begin
        if (bus.ir_lh) ir[15:8] <= mem_out_s;
        else           ir[7:0]  <= mem_out_s;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic [7:0]  pc;
    logic [7:0]  ar;
    logic [7:0]  m;
    logic [31:0] regs;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_r   [4];
  logic [7:0]  ref_ar;
  logic        ref_z;
  logic [15:0] ref_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Instruction-set interpreter: runs from address 0 until the halt opcode.
  task automatic ref_run();
    logic [7:0]  rpc;
    logic [15:0] ins;
    logic [3:0]  op;
    logic [1:0]  rd, rs;
    logic [7:0]  imm;
    logic        halt;
    exp_t        e;
    rpc  = 8'h00;
    halt = 1'b0;
    for (int n = 0; n < 200 && !halt; n++) begin
      ins = {ref_mem[rpc + 8'd1], ref_mem[rpc]};
      rpc = rpc + 8'd2;
      op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
      case (op)
        4'h0: begin ref_r[rd] = imm; ref_z = (imm == 8'h00); end
        4'h1: ref_ar = imm;
        4'h2: begin ref_r[rd] = ref_mem[ref_ar]; ref_z = (ref_r[rd] == 8'h00); end
        4'h3: ref_mem[ref_ar] = ref_r[rd];
        4'hC: begin ref_r[rd] = ref_r[rd] + 8'd1; ref_z = (ref_r[rd] == 8'h00); end
        4'hD: begin ref_r[rd] = ref_r[rd] - 8'd1; ref_z = (ref_r[rd] == 8'h00); end
        4'hE: if (ref_z) rpc = imm;
        4'hF: halt = 1'b1;
        default: begin
          ref_r[rd] = alu_f(op, ref_r[rd], ref_r[rs]);
          ref_z     = (ref_r[rd] == 8'h00);
        end
      endcase
      ref_cnt  = ref_cnt + 16'd1;
      e.pc     = rpc;
      e.ar     = ref_ar;
      e.m      = ref_mem[ref_ar];
      e.regs   = {ref_r[0], ref_r[1], ref_r[2], ref_r[3]};
      e.halted = halt;
      e.cnt    = ref_cnt;
      exp_q.push_back(e);
    end
  endtask

  // Retirement monitor: each InstrCount step pops one expected architectural state.
  initial begin
    logic [15:0] prev_cnt;
    int          wr_run;
    exp_t        e;
    logic        exp_busy;
    prev_cnt = 16'h0000;
    wr_run   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cnt = 16'h0000;
        wr_run   = 0;
      end else begin
        if (!bus.mem_cs && bus.mem_wr) begin
          wr_run++;
        end else begin
          if (wr_run != 0) check("st_pulse_width", wr_run, 1);
          wr_run = 0;
        end
        if (bus.instr_count == prev_cnt + 16'd1) begin
          if (exp_q.size() == 0) begin
            check("retire_expected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
`ifdef SEQ_SINGLE_STEP_EN
            exp_busy = 1'b0;
`else
            exp_busy = !e.halted;
`endif
            check("instr_count", bus.instr_count, e.cnt);
            check("pc", pc, e.pc);
            check("ar", ar, e.ar);
            check("regs", {rf[0], rf[1], rf[2], rf[3]}, e.regs);
            check("mem_at_ar", mem[e.ar], e.m);
            check("halted", bus.halted, e.halted);
            check("busy", bus.busy, exp_busy);
            check("rf_tsel", bus.rf_tsel, 0);
          end
        end
        prev_cnt = bus.instr_count;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic mem_load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic run_program(input logic [15:0] prog[$], input logic hold);
    int          cyc;
    logic [15:0] c0;
    for (int i = 0; i < prog.size(); i++) begin
      mem_load(8'(2*i), prog[i][7:0]);
      mem_load(8'(2*i+1), prog[i][15:8]);
    end
    ref_run();
    c0 = bus.instr_count;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    cyc = 0;
    while (bus.instr_count == c0 && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    check("first_retire_latency", cyc, 3);
    cyc = 0;
    while (!bus.halted && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    bus.start = 1'b0;
    check("halt_reached", bus.halted, 1'b1);
    c0 = bus.instr_count;
    repeat (3) @(posedge clk);
    #1;
    check("count_frozen_in_halt", bus.instr_count, c0);
    check("halt_mem_cs", bus.mem_cs, 1'b1);
    check("halt_busy", bus.busy, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p[$];
    int          len;
    logic [3:0]  op;
    logic [7:0]  imm;
    total = 0; bad = 0;
    rst = 1'b1; env_clr = 1'b1; bus.start = 1'b0;
    ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
    ref_ar = 8'h00; ref_z = 1'b0; ref_cnt = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_count", bus.instr_count, 0);
    check("rst_mem_cs", bus.mem_cs, 1'b1);
    check("rst_arf_rsel", bus.arf_rsel, 0);
    check("rst_ir_enable", bus.ir_enable, 1'b0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    env_clr = 1'b0; rst = 1'b0;
    for (int a = 0; a < 256; a++) mem_load(8'(a), (a >= 128) ? 8'($urandom) : 8'h00);

    p = '{16'h043C, 16'hF000};                 run_program(p, 1'b0);
    p = '{16'h0005, 16'h0403, 16'h4100, 16'hF000}; run_program(p, 1'b0);
    p = '{16'h1020, 16'h3000, 16'hF000};       run_program(p, 1'b0);
    p = '{16'h0001, 16'hD000, 16'hE010, 16'hF000, 16'hF000, 16'hF000,
          16'hF000, 16'hF000, 16'hF000};       run_program(p, 1'b0);
    p = '{16'h0002, 16'hD000, 16'hE010, 16'hF000}; run_program(p, 1'b1);

    for (int t = 0; t < 12; t++) begin
      p.delete();
      len = $urandom_range(16, 4);
      for (int i = 0; i < len - 1; i++) begin
        op  = 4'($urandom_range(14, 0));
        imm = 8'($urandom);
        if (op == 4'h1) imm = 8'($urandom_range(255, 128));
        if (op == 4'hE) imm = 8'(2 * $urandom_range(len - 1, i + 1));
        p.push_back({op, 2'($urandom), 2'($urandom), imm});
      end
      p.push_back(16'hF000);
      run_program(p, t[0]);
    end

    // Reset while the high instruction byte is being fetched.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("fetch_h_busy", bus.busy, 1'b1);
    check("fetch_h_ir_lh", bus.ir_lh, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_mem_cs", bus.mem_cs, 1'b1);
    check("midrst_ir_enable", bus.ir_enable, 1'b0);
    check("midrst_arf_rsel", bus.arf_rsel, 0);
    check("midrst_count", bus.instr_count, 0);
    exp_q.delete();
    ref_cnt = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    p = '{16'h0C7E, 16'hC300, 16'hF000};
    run_program(p, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
